sm_regwr_arbiter: RTL and testbench
===================================

Name: sm_regwr_arbiter

Overview:
- Shares the single register-file write port of the schoolRISCV core among N requesters, e.g. CPU writeback, debug/loader port and a multi-cycle unit.
- Round-robin arbitration with valid/ready handshake per requester.
- Optional bounded burst lock lets one requester hold the port for consecutive writes.
- Registered output stage drives the register-file write port (wa/wd/we), 1-cycle latency.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BURST, 4, max consecutive grants under lock (1..16; 1 disables locking).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold: no grants while 1.
- req_valid  in  N  per-requester write request.
- req_lock  in  N  per-requester burst-lock request, meaningful only with req_valid.
- req_addr  in  N*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  N*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W].
- req_ready  out  N  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- we  out  1  register-file write enable (registered).
- wa  out  ADDR_W  register-file write address (registered).
- wd  out  DATA_W  register-file write data (registered).
- owner  out  $clog2(N)  index of last granted requester (registered, debug).
- locked  out  1  1 while in LOCKED state.

Behaviour:
- Reset (rst=0, async): we=0, wa=0, wd=0, owner=0, locked=0, ptr=0, burst_cnt=0, state=IDLE. req_ready forced to 0 while rst=0.
- req_ready is combinational from state, ptr, req_valid and stall. At most one bit is set. It is never set for a requester whose req_valid=0.
- IDLE:
  - Grant the first valid requester scanning ptr, ptr+1, ..., wrapping mod N.
  - On grant to i: ptr<=(i+1) mod N, owner<=i.
  - If req_lock[i]=1 and MAX_BURST>1: state<=LOCKED, burst_cnt<=1.
- LOCKED:
  - Grant only owner, while req_valid[owner]=1 and req_lock[owner]=1. Each such grant increments burst_cnt.
  - Release to IDLE in the same cycle any of these holds: req_valid[owner]=0, req_lock[owner]=0, or burst_cnt==MAX_BURST.
  - On release, the grant that cycle is decided by IDLE rules, with owner excluded when releasing on the burst limit. ptr already points past owner.
  - After the burst limit, owner cannot be re-granted until every other valid requester has had one grant.
- Output stage: in the cycle after a transfer, we=1, wa=addr, wd=data. With no transfer, next cycle we=0; wa/wd hold their previous values.
- Address 0 (x0):
  - Request is still accepted (ready=1) and ptr and burst_cnt advance.
  - we stays 0, so the write is dropped.
- Stall=1:
  - req_ready=0 and we<=0 next cycle.
  - ptr, state, owner and burst_cnt hold. A lock survives the stall.
- Requester deasserting valid without ready: allowed, no side effects.
- Reset asserted mid-burst: immediate return to reset values; any registered but not-yet-consumed write is lost.
- Throughput: one write per cycle maximum, no bubbles between grants.

Decomposition:
- Shared header sm_regwr_defs.vh holds:
  - state encodings: IDLE=1'b0, LOCKED=1'b1;
  - default widths DATA_W=32, ADDR_W=5;
  - the x0 address constant.
- One combinational sub-module, sm_rr_pick: inputs N-bit request, start pointer and exclude mask; outputs one-hot grant and its index. It is reused by later arbiters.

Test Plan:
- Reset/basic: rst low 3 cycles with all req_valid=1 -> req_ready=0, we=0. After release with only req_valid[0], addr=3, data=0xDEADBEEF: next cycle we=1, wa=3, wd=0xDEADBEEF.
- Round-robin fairness: all 4 requesters valid continuously, no lock -> grants 0,1,2,3,0,1 on consecutive cycles; we=1 every cycle after the first.
- Burst limit: requester 2 with lock and MAX_BURST=4, requesters 0 and 3 also valid -> 2,2,2,2,3,0, then 2. The locked output is 1 during the burst and 0 from the 5th grant.
- x0 drop: requester 1 writes addr=0 then addr=7 -> both handshakes complete; we=0 for the first write and we=1, wa=7 for the second; ptr advances twice.
- Stall mid-lock: requester 1 locked with 2 grants done, stall=1 for 3 cycles -> req_ready=0 and we=0 during the stall. After stall=0, requester 1 receives exactly 2 more grants, then release.
- Async reset mid-burst: drop rst between clock edges during LOCKED -> locked, we and req_ready fall immediately. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/sm_regwr_arbiter_pkg.sv
// Shared definitions for the schoolRISCV register-file write-port arbiter:
// FSM encoding, default widths and the hard-wired x0 register address.
package sm_regwr_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int X0_ADDR    = 0;

endpackage

// File: rtl/sm_rr_pick.sv
// Combinational round-robin picker: first set bit of (i_req & ~i_excl) scanning
// from i_start upward with wrap-around; returns one-hot grant and its index.
module sm_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_start,
    input  logic [N-1:0]         i_excl,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    logic [N-1:0] w_cand;

    always_comb begin
        int pos;
        w_cand  = i_req & ~i_excl;
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(i_start) + k) % N;
            if (w_cand[pos]) begin
                o_idx = IW'(pos);
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant = N'(1) << o_idx;
        end
    end

endmodule

// File: rtl/sm_regwr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N requesters,
// with bounded burst locking and a registered we/wa/wd output stage.
module sm_regwr_arbiter
    import sm_regwr_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_lock,
    input  logic [N*ADDR_W-1:0]  req_addr,
    input  logic [N*DATA_W-1:0]  req_data,
    output logic [N-1:0]         req_ready,
    output logic                 we,
    output logic [ADDR_W-1:0]    wa,
    output logic [DATA_W-1:0]    wd,
    output logic [$clog2(N)-1:0] owner,
    output logic                 locked
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t        r_state, w_state_nxt;
    logic [IW-1:0]     r_ptr, w_ptr_nxt;
    logic [IW-1:0]     r_owner, w_owner_nxt;
    logic [CW-1:0]     r_burst_cnt, w_burst_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;

    logic              w_at_limit, w_continue, w_xfer;
    logic [N-1:0]      w_excl, w_pick_grant, w_grant;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_at_limit = (r_burst_cnt == CW'(MAX_BURST));
    assign w_continue = (r_state == LOCKED) && req_valid[r_owner] &&
                        req_lock[r_owner] && !w_at_limit;
    // A burst that ran out hands the port on; the owner sits out this pick.
    assign w_excl     = ((r_state == LOCKED) && w_at_limit) ? (N'(1) << r_owner) : '0;

    sm_rr_pick #(.N(N)) u_pick (
        .i_req   (req_valid),
        .i_start (r_ptr),
        .i_excl  (w_excl),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_grant     = '0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        if (!stall) begin
            if (w_continue) begin
                w_grant     = N'(1) << r_owner;
                w_burst_nxt = r_burst_cnt + CW'(1);
            end else begin
                w_state_nxt = IDLE;
                w_burst_nxt = '0;
                if (w_pick_any) begin
                    w_grant     = w_pick_grant;
                    w_owner_nxt = w_pick_idx;
                    w_ptr_nxt   = (w_pick_idx == IW'(N - 1)) ? '0 : w_pick_idx + IW'(1);
                    if (req_lock[w_pick_idx] && (MAX_BURST > 1)) begin
                        w_state_nxt = LOCKED;
                        w_burst_nxt = CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer    = |w_grant;
    assign req_ready = rst ? w_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Output stage: writes to x0 are accepted upstream but never reach the file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else begin
            r_we <= w_xfer && (w_addr != ADDR_W'(X0_ADDR));
            if (w_xfer) begin
                r_wa <= w_addr;
                r_wd <= w_data;
            end
        end
    end

    assign we     = r_we;
    assign wa     = r_wa;
    assign wd     = r_wd;
    assign owner  = r_owner;
    assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_sm_regwr_arbiter.sv
// Self-checking bench for sm_regwr_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural arbitration model.
module tb_sm_regwr_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [N-1:0]  req_valid, req_lock, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    owner;
    logic          locked;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            m_locked;
    int            m_ptr, m_owner, m_cnt;
    bit            m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    int exp_rr[6]    = '{0, 1, 2, 3, 0, 1};
    int exp_bg[7]    = '{2, 2, 2, 2, 3, 0, 2};
    int exp_bl[7]    = '{1, 1, 1, 1, 0, 0, 1};
    int exp_sg[3]    = '{1, 1, 3};
    int exp_sl[3]    = '{1, 1, 0};

    always #5 clk = ~clk;

    sm_regwr_arbiter #(.N(N), .MAX_BURST(MB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .owner     (owner),
        .locked    (locked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx, cnt;
        idx = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] === 1'b1) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    function automatic int pick_model();
        int i;
        if (stall) return -1;
        if (m_locked && req_valid[m_owner] && req_lock[m_owner] && m_cnt < MB) return m_owner;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && !(m_locked && m_cnt == MB && i == m_owner)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        m_we = 0; m_wa = '0; m_wd = '0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Called just after a posedge with inputs already driven; returns the DUT grant.
    task automatic step(output int dg);
        int            g;
        bit            cont, lk, st;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        st   = stall;
        cont = !stall && m_locked && req_valid[m_owner] && req_lock[m_owner] && m_cnt < MB;
        g    = pick_model();
        lk   = (g >= 0) ? req_lock[g] : 1'b0;
        a    = (g >= 0) ? req_addr[g*AW +: AW] : '0;
        d    = (g >= 0) ? req_data[g*DW +: DW] : '0;
        check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        dg = onehot_idx(req_ready);
        @(posedge clk);
        if (!st) begin
            if (cont) begin
                m_cnt++;
            end else begin
                m_locked = 0;
                m_cnt    = 0;
                if (g >= 0) begin
                    m_owner = g;
                    m_ptr   = (g + 1) % N;
                    if (lk && MB > 1) begin
                        m_locked = 1;
                        m_cnt    = 1;
                    end
                end
            end
        end
        m_we = (g >= 0) && (a != '0);
        if (g >= 0) begin
            m_wa = a;
            m_wd = d;
        end
        #1;
        check("we", we, m_we);
        check("wa", wa, m_wa);
        check("wd", wd, m_wd);
        check("owner", owner, m_owner);
        check("locked", locked, m_locked);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_we", we, 0);
        check("rst_locked", locked, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dg;
        rst = 1'b0; stall = 1'b0;
        req_valid = '1; req_lock = '0; req_addr = '0; req_data = '0;
        model_reset();

        // Reset with every requester asking
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_ready", req_ready, 0);
            check("reset_we", we, 0);
            check("reset_wa", wa, 0);
            check("reset_wd", wd, 0);
            check("reset_owner", owner, 0);
            check("reset_locked", locked, 0);
        end
        rst = 1'b1;
        req_valid = 4'b0001;
        set_addr(0, 5'd3, 32'hDEADBEEF);
        step(dg);
        check("basic_grant", dg, 0);
        check("basic_we", we, 1);
        check("basic_wa", wa, 3);
        check("basic_wd", wd, 32'hDEADBEEF);
        req_valid = '0;
        step(dg);

        // Round-robin fairness
        do_reset();
        req_valid = '1; req_lock = '0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(i + 8), DW'($urandom));
        for (int k = 0; k < 6; k++) begin
            step(dg);
            check("rr_grant", dg, exp_rr[k]);
            check("rr_we", we, 1);
        end

        // Burst limit with requesters 0 and 3 waiting
        do_reset();
        req_valid = 4'b0100; req_lock = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            step(dg);
            check("burst_grant", dg, exp_bg[k]);
            check("burst_locked", locked, exp_bl[k]);
            req_valid = 4'b1101;
        end

        // x0 write dropped, handshake still completes
        do_reset();
        req_valid = 4'b0010; req_lock = '0;
        set_addr(1, 5'd0, 32'h1111_0000);
        step(dg);
        check("x0_grant", dg, 1);
        check("x0_we", we, 0);
        set_addr(1, 5'd7, 32'h2222_0007);
        step(dg);
        check("x7_grant", dg, 1);
        check("x7_we", we, 1);
        check("x7_wa", wa, 7);
        req_valid = '1;
        step(dg);
        check("x0_ptr_after", dg, 2);

        // Stall in the middle of a locked burst
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        set_addr(1, 5'd9, 32'hCAFE0001);
        set_addr(3, 5'd4, 32'hCAFE0003);
        step(dg);
        step(dg);
        stall = 1'b1;
        repeat (3) begin
            step(dg);
            check("stall_ready", dg, -1);
            check("stall_we", we, 0);
            check("stall_locked", locked, 1);
        end
        stall = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step(dg);
            check("stall_resume_grant", dg, exp_sg[k]);
            check("stall_resume_locked", locked, exp_sl[k]);
        end

        // Asynchronous reset during a burst
        do_reset();
        req_valid = 4'b0100; req_lock = 4'b0100;
        step(dg);
        step(dg);
        req_valid = '1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_we", we, 0);
        check("arst_ready", req_ready, 0);
        check("arst_owner", owner, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        req_lock = '0;
        step(dg);
        check("arst_restart", dg, 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            req_valid = N'($urandom);
            req_lock  = N'($urandom) | N'($urandom);
            stall     = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) set_addr(i, AW'($urandom_range(0, 31)), DW'($urandom));
            step(dg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
